// File: rtl/reaction_game_pkg.sv
// Shared constants, state encoding and seven-segment helpers for the reaction-time game.
package reaction_game_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      TIMING = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned TICK_DIV_REAL   = 500000;
   localparam int unsigned TICK_DIV_SIM    = 50;
   localparam int unsigned DEBOUNCE_CYCLES = 250000;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [8:0] DELAY_BASE = 9'd100;
   localparam logic [6:0] TIMER_MAX  = 7'd99;

   localparam logic [7:0] SEG_DASH = 8'hBF;
   localparam logic [7:0] SEG_ZERO = 8'hC0;

   function automatic int unsigned tick_div(input int sim_mode);
      return (sim_mode != 0) ? TICK_DIV_SIM : TICK_DIV_REAL;
   endfunction

   // active-low {dp,g,f,e,d,c,b,a}, dp off
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/reaction_game_timer.sv
// Round FSM, random delay countdown, centisecond divider and elapsed-time counter.
// Optional best-score tracking under RG_BEST_SCORE_EN.
module rg_timer
   import reaction_game_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_REAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] seed_byte,
   output state_t     cur_state,
   output logic [6:0] oTIMER,
   output logic       false_start
`ifdef RG_BEST_SCORE_EN
   ,
   output logic [6:0] best,
   output logic       new_best
`endif
);

   localparam int unsigned DW = $clog2(TICK_DIV);

   state_t        state, state_n;
   logic [8:0]    delay, delay_n;
   logic [6:0]    timer_n;
   logic          fs_n;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic          enter_count;

   assign tick        = (div_cnt == DW'(TICK_DIV - 1));
   assign enter_count = (state_n != state) && ((state_n == WAIT) || (state_n == TIMING));
   assign cur_state   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         delay       <= '0;
         oTIMER      <= '0;
         false_start <= 1'b0;
      end else begin
         state       <= state_n;
         delay       <= delay_n;
         oTIMER      <= timer_n;
         false_start <= fs_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if (enter_count || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // stop has priority over start in every state
   always_comb begin
      state_n = state;
      delay_n = delay;
      timer_n = oTIMER;
      fs_n    = false_start;
      case (state)
         IDLE, DONE: begin
            if (start && !stop) begin
               state_n = WAIT;
               delay_n = DELAY_BASE + {1'b0, seed_byte};
               timer_n = '0;
               fs_n    = 1'b0;
            end
         end
         WAIT: begin
            if (stop) begin
               state_n = DONE;
               fs_n    = 1'b1;
            end else if (delay == '0) begin
               state_n = TIMING;
            end else if (tick) begin
               delay_n = delay - 1'b1;
            end
         end
         TIMING: begin
            if (stop)
               state_n = DONE;
            else if (tick && (oTIMER != TIMER_MAX))
               timer_n = oTIMER + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef RG_BEST_SCORE_EN
   logic beat;
   assign beat = (state == TIMING) && (state_n == DONE) && (oTIMER < best);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best     <= TIMER_MAX;
         new_best <= 1'b0;
      end else if (beat) begin
         best     <= oTIMER;
         new_best <= 1'b1;
      end else if ((state_n == WAIT) && (state != WAIT)) begin
         new_best <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/reaction_game_top.sv
// DE10-Lite reaction-time game top: reset/key conditioning, LFSR, LEDs and HEX display.
// Optional best-score display/LED behaviour under RG_BEST_SCORE_EN.
module reaction_game_top
   import reaction_game_pkg::*;
#(
   parameter int SIM_MODE = 0
) (
   input  logic       CLK_50,
   input  logic       RESET,
   input  logic [1:0] KEY,
   output logic [9:0] LEDR,
   output logic [7:0] HEX0,
   output logic [7:0] HEX1
);

   logic [1:0]  rst_sync;
   logic        rst;
   logic [1:0]  key_s1, key_s2, key_acc, key_prev, press;
   logic [15:0] lfsr;
   state_t      state;
   logic [6:0]  timer_val;
   logic        false_start;
   logic [6:0]  shown;
`ifdef RG_BEST_SCORE_EN
   logic [6:0]  best;
   logic        new_best;
`endif

   // async assert, release two clocks after RESET drops
   always_ff @(posedge CLK_50 or posedge RESET) begin
      if (RESET)
         rst_sync <= '1;
      else
         rst_sync <= {rst_sync[0], 1'b0};
   end
   assign rst = rst_sync[1];

   always_ff @(posedge CLK_50 or posedge rst) begin
      if (rst) begin
         key_s1   <= '1;
         key_s2   <= '1;
         key_prev <= '1;
      end else begin
         key_s1   <= KEY;
         key_s2   <= key_s1;
         key_prev <= key_acc;
      end
   end

   generate
      if (SIM_MODE != 0) begin : g_nofilt
         assign key_acc = key_s2;
      end else begin : g_filt
         localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
         logic [CW-1:0] cnt [2];

         // a new level is accepted only after holding for the full window
         always_ff @(posedge CLK_50 or posedge rst) begin
            if (rst) begin
               key_acc <= '1;
               for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
            end else begin
               for (int unsigned i = 0; i < 2; i++) begin
                  if (key_s2[i] == key_acc[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                     key_acc[i] <= key_s2[i];
                     cnt[i]     <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   assign press = key_prev & ~key_acc;

   always_ff @(posedge CLK_50 or posedge rst) begin
      if (rst)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   rg_timer #(
      .TICK_DIV (tick_div(SIM_MODE))
   ) u_timer (
      .clk         (CLK_50),
      .rst         (rst),
      .start       (press[0]),
      .stop        (press[1]),
      .seed_byte   (lfsr[7:0]),
      .cur_state   (state),
      .oTIMER      (timer_val),
      .false_start (false_start)
`ifdef RG_BEST_SCORE_EN
      ,
      .best        (best),
      .new_best    (new_best)
`endif
   );

   always_comb begin
      LEDR = '0;
      case (state)
         TIMING: LEDR = '1;
         DONE: begin
            if (!false_start) begin
               LEDR = '1;
`ifdef RG_BEST_SCORE_EN
               if (!new_best) LEDR[9] = 1'b0;
`endif
            end
         end
         default: LEDR = '0;
      endcase
   end

   always_comb begin
      shown = timer_val;
`ifdef RG_BEST_SCORE_EN
      if (state == IDLE) shown = best;
`endif
   end

   always_ff @(posedge CLK_50 or posedge rst) begin
      if (rst) begin
         HEX0 <= SEG_ZERO;
         HEX1 <= SEG_ZERO;
      end else if (false_start) begin
         HEX0 <= SEG_DASH;
         HEX1 <= SEG_DASH;
      end else begin
         HEX1 <= seg7(4'(shown / 7'd10));
         HEX0 <= seg7(4'(shown % 7'd10));
      end
   end

endmodule

// File: tb/tb_reaction_game_top.sv
// Directed-plus-random bench for reaction_game_top in SIM_MODE=1 with a cycle-level timeline model.
module tb_reaction_game_top;

   logic       clk = 1'b0;
   logic       RESET;
   logic [1:0] KEY;
   logic [9:0] LEDR;
   logic [7:0] HEX0, HEX1;

   int unsigned edges = 0;
   int unsigned c0 = 0;
   int unsigned passed = 0;
   int unsigned total = 0;

   logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   reaction_game_top #(.SIM_MODE(1)) dut (
      .CLK_50 (clk),
      .RESET  (RESET),
      .KEY    (KEY),
      .LEDR   (LEDR),
      .HEX0   (HEX0),
      .HEX1   (HEX1)
   );

   always #10 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic at_edge(input int unsigned n);
      while (edges < n) @(negedge clk);
   endtask

   function automatic int unsigned lfsr_next(input int unsigned x);
      int unsigned fb;
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
      return ((x << 1) | fb) & 32'hFFFF;
   endfunction

   function automatic int unsigned lfsr_after(input int unsigned n);
      int unsigned x = 32'hACE1;
      repeat (n) x = lfsr_next(x);
      return x;
   endfunction

   // start press whose KEY fall is first seen at edge a; delay sampled from LFSR value after edge a+1
   task automatic start_round(output int unsigned a, output int unsigned d, output int unsigned t);
      int unsigned g, v;
      g = $urandom_range(2, 20);
      v = lfsr_after(edges + g - c0);
      while (((v & 32'hFF) >= 48) && (g < 2000)) begin
         v = lfsr_next(v);
         g++;
      end
      repeat (g) @(negedge clk);
      a = edges + 1;
      KEY[0] = 1'b0;
      repeat (3) @(negedge clk);
      KEY[0] = 1'b1;
      d = 100 + (v & 32'hFF);
      t = a + 3 + 50 * d;
   endtask

   task automatic press_stop(input int unsigned b);
      at_edge(b - 1);
      KEY[1] = 1'b0;
      repeat (3) @(negedge clk);
      KEY[1] = 1'b1;
   endtask

   function automatic int unsigned expected_time(input int unsigned t, input int unsigned b);
      int unsigned e;
      e = (b + 1 - t) / 50;
      return (e > 99) ? 99 : e;
   endfunction

   initial begin
      int unsigned a, d, t, b, e;

      RESET = 1'b1;
      KEY   = 2'b11;
      repeat (10) @(negedge clk);
      check("reset_state", dut.u_timer.state, 0);
      check("reset_ledr", LEDR, 10'h000);
      check("reset_hex0", HEX0, 8'hC0);
      check("reset_hex1", HEX1, 8'hC0);
      check("reset_timer", dut.u_timer.oTIMER, 0);
      RESET = 1'b0;
      c0 = edges;
      repeat (5) @(negedge clk);

      KEY = 2'b00;
      repeat (3) @(negedge clk);
      KEY = 2'b11;
      repeat (4) @(negedge clk);
      check("both_keys_idle", dut.u_timer.state, 0);

      // round 1: run to saturation
      start_round(a, d, t);
      at_edge(a + 2);
      check("r1_wait", dut.u_timer.state, 1);
      at_edge(t - 1);
      check("r1_wait_end_state", dut.u_timer.state, 1);
      check("r1_wait_end_ledr", LEDR, 10'h000);
      at_edge(t);
      check("r1_timing", dut.u_timer.state, 2);
      check("r1_timing_ledr", LEDR, 10'h3FF);
      b = t + 6000;
      press_stop(b);
      at_edge(b + 2);
      check("r1_done", dut.u_timer.state, 3);
      at_edge(b + 4);
      check("r1_timer", dut.u_timer.oTIMER, expected_time(t, b));
      check("r1_hex1", HEX1, 8'h90);
      check("r1_hex0", HEX0, 8'h90);
      check("r1_ledr", LEDR, 10'h3FF);

      // round 2: from DONE, start ignored in TIMING, 24 cs
      start_round(a, d, t);
      at_edge(a + 2);
      check("r2_wait", dut.u_timer.state, 1);
      at_edge(t);
      check("r2_timing", dut.u_timer.state, 2);
      at_edge(t + 300);
      KEY[0] = 1'b0;
      repeat (3) @(negedge clk);
      KEY[0] = 1'b1;
      repeat (5) @(negedge clk);
      check("r2_start_ignored", dut.u_timer.state, 2);
      b = t + 1234;
      press_stop(b);
      at_edge(b + 4);
      check("r2_timer", dut.u_timer.oTIMER, 24);
      check("r2_hex1", HEX1, 8'hA4);
      check("r2_hex0", HEX0, 8'h99);

      // round 3: random stop point
      start_round(a, d, t);
      at_edge(t);
      check("r3_timing", dut.u_timer.state, 2);
      b = t + $urandom_range(1, 5300);
      e = expected_time(t, b);
      press_stop(b);
      at_edge(b + 4);
      check("r3_timer", dut.u_timer.oTIMER, e);
      check("r3_hex1", HEX1, segtab[e / 10]);
      check("r3_hex0", HEX0, segtab[e % 10]);
      press_stop(edges + 3);
      repeat (200) @(negedge clk);
      check("r3_stop_in_done_state", dut.u_timer.state, 3);
      check("r3_stop_in_done_timer", dut.u_timer.oTIMER, e);

      // round 4: false start
      start_round(a, d, t);
      b = a + 5 + $urandom_range(0, 50 * d - 10);
      press_stop(b);
      at_edge(b + 2);
      check("fs_state", dut.u_timer.state, 3);
      check("fs_flag", dut.u_timer.false_start, 1);
      check("fs_ledr", LEDR, 10'h000);
      at_edge(b + 4);
      check("fs_hex1", HEX1, 8'hBF);
      check("fs_hex0", HEX0, 8'hBF);

      // round 5: restart after false start, then reset mid-TIMING
      start_round(a, d, t);
      at_edge(a + 2);
      check("r5_wait", dut.u_timer.state, 1);
      check("r5_flag_clear", dut.u_timer.false_start, 0);
      at_edge(a + 4);
      check("r5_hex1", HEX1, 8'hC0);
      check("r5_hex0", HEX0, 8'hC0);
      at_edge(t);
      check("r5_timing", dut.u_timer.state, 2);
      at_edge(t + $urandom_range(100, 1000));
      RESET = 1'b1;
      #1;
      check("rst_mid_state", dut.u_timer.state, 0);
      check("rst_mid_timer", dut.u_timer.oTIMER, 0);
      check("rst_mid_ledr", LEDR, 10'h000);
      check("rst_mid_hex0", HEX0, 8'hC0);
      check("rst_mid_hex1", HEX1, 8'hC0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
